// File: rtl/layer_compositor.sv
// Priority/colour-key compositor for the VGA path: merges N_LAYERS sprite/maze layers
// into one registered 12-bit rgb stream, two cycles behind the timing inputs.
module layer_compositor #(
  parameter int          N_LAYERS  = 4,
  parameter logic [11:0] KEY_COLOR = 12'h000,
  parameter int          START_H   = 150,
  parameter int          END_H     = 630,
  parameter int          START_V   = 34,
  parameter int          END_V     = 514,
  parameter int          BLINK_BIT = 4,
  parameter int          FC_W      = 8,
  localparam int         HL_W      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bright,
  input  logic [9:0]             hCount,
  input  logic [9:0]             vCount,
  input  logic [N_LAYERS-1:0]    layer_fill,
  input  logic [12*N_LAYERS-1:0] layer_color,
  input  logic                   en_wr,
  input  logic [N_LAYERS-1:0]    en_data,
  input  logic                   bg_wr,
  input  logic [11:0]            bg_data,
  input  logic [N_LAYERS-1:0]    blink_mask,
  output logic [11:0]            rgb,
  output logic [11:0]            background,
  output logic                   hit_valid,
  output logic [HL_W-1:0]        hit_layer,
  output logic [FC_W-1:0]        frame_count
);

  localparam logic [9:0] SH = START_H[9:0];
  localparam logic [9:0] EH = END_H[9:0];
  localparam logic [9:0] SV = START_V[9:0];
  localparam logic [9:0] EV = END_V[9:0];

  logic [N_LAYERS-1:0]    layer_en;
  logic                   origin_d;
  logic                   origin;
  logic                   new_frame;
  logic                   in_window;
  logic                   blink_off;
  logic [N_LAYERS-1:0]    vis;

  logic                   bright_d;
  logic                   in_window_d;
  logic [N_LAYERS-1:0]    vis_d;
  logic [12*N_LAYERS-1:0] color_d;

  logic                   win_any;
  logic [HL_W-1:0]        win_idx;
  logic [11:0]            win_color;

  assign origin    = (hCount == 10'd0) && (vCount == 10'd0);
  assign new_frame = origin && !origin_d;
  assign in_window = (hCount >= SH) && (hCount <= EH) && (vCount >= SV) && (vCount <= EV);
  // Blink phase is taken from the counter as the pixel enters stage 1.
  assign blink_off = frame_count[BLINK_BIT];

  always_comb begin
    vis = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      vis[i] = layer_fill[i] && layer_en[i]
               && (layer_color[12*i +: 12] != KEY_COLOR)
               && in_window
               && !(blink_mask[i] && blink_off);
    end
  end

  // Walk from lowest priority upward so the lowest visible index wins.
  always_comb begin
    win_any   = 1'b0;
    win_idx   = '0;
    win_color = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (vis_d[i]) begin
        win_any   = 1'b1;
        win_idx   = HL_W'(i);
        win_color = color_d[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      layer_en    <= '1;
      background  <= 12'h000;
      origin_d    <= 1'b0;
      frame_count <= '0;
      bright_d    <= 1'b0;
      in_window_d <= 1'b0;
      vis_d       <= '0;
      color_d     <= '0;
      rgb         <= 12'h000;
      hit_valid   <= 1'b0;
      hit_layer   <= '0;
    end else begin
      if (en_wr) layer_en <= en_data;
      if (bg_wr) background <= bg_data;

      origin_d <= origin;
      if (new_frame) frame_count <= frame_count + FC_W'(1);

      bright_d    <= bright;
      in_window_d <= in_window;
      vis_d       <= vis;
      color_d     <= layer_color;

      if (!bright_d) begin
        rgb       <= 12'h000;
        hit_valid <= 1'b0;
      end else if (win_any) begin
        rgb       <= win_color;
        hit_valid <= 1'b1;
        hit_layer <= win_idx;
      end else begin
        // hit_layer intentionally keeps the last winner.
        rgb       <= background;
        hit_valid <= 1'b0;
      end
    end
  end

endmodule
